noc_page_client: RTL

- Ant-side endpoint of one NoC port; the counterpart of the network's per-port requester/responder pair.
- Fetch side: takes remote page ids from the local pagerank16 compute block and drives the port's 6-bit request. It captures the matching response {value, page id} and returns the value to compute.
- Serve side: answers the network's query_id with the local page value, read from a 16-entry table that compute writes.
- Adds a last-value bypass, a response timeout with retry, and an error flag.

---
 rtl/noc_page_client.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/noc_page_client.sv
// rtl/noc_page_client.sv - NoC port endpoint: remote page fetch client and local page table server
// Optional statistics counters are built when NOC_PAGE_CLIENT_STATS_EN is defined.
module noc_page_client #(
  parameter int         DATA_W     = 16,
  parameter int         TIMEOUT    = 64,
  parameter int         MAX_RETRY  = 3,
  parameter logic [5:0] LOCAL_BASE = 6'd16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_valid,
  input  logic [5:0]          fetch_id,
  output logic                fetch_ready,
  output logic                val_valid,
  output logic [5:0]          val_id,
  output logic [DATA_W-1:0]   val_data,
  input  logic                val_ready,
  output logic [5:0]          request,
  input  logic [DATA_W+5:0]   response,
  input  logic [5:0]          query_id,
  output logic [DATA_W-1:0]   reply,
  input  logic                tbl_we,
  input  logic [3:0]          tbl_addr,
  input  logic [DATA_W-1:0]   tbl_wdata,
  output logic                error,
  output logic [15:0]         stat_req,
  output logic [15:0]         stat_retry,
  output logic [15:0]         stat_hit
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [15:0] TIMEOUT_M1  = 16'(TIMEOUT - 1);
  localparam logic [7:0]  MAX_RETRY_W = 8'(MAX_RETRY);

  state_t              state_q, state_d;
  logic [5:0]          cur_id_q, cur_id_d;
  logic [5:0]          last_id_q, last_id_d;
  logic [DATA_W-1:0]   last_val_q, last_val_d;
  logic                last_val_ok_q, last_val_ok_d;
  logic [5:0]          val_id_q, val_id_d;
  logic [DATA_W-1:0]   val_data_q, val_data_d;
  logic [15:0]         timer_q, timer_d;
  logic [7:0]          retry_q, retry_d;
  logic                error_q, error_d;
  logic [DATA_W-1:0]   tbl_q [16];
  logic [DATA_W-1:0]   tbl_d [16];
  logic                inc_req, inc_retry, inc_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cur_id_q      <= '0;
      last_id_q     <= '0;
      last_val_q    <= '0;
      last_val_ok_q <= 1'b0;
      val_id_q      <= '0;
      val_data_q    <= '0;
      timer_q       <= '0;
      retry_q       <= '0;
      error_q       <= 1'b0;
      for (int i = 0; i < 16; i++) tbl_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      cur_id_q      <= cur_id_d;
      last_id_q     <= last_id_d;
      last_val_q    <= last_val_d;
      last_val_ok_q <= last_val_ok_d;
      val_id_q      <= val_id_d;
      val_data_q    <= val_data_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      error_q       <= error_d;
      for (int i = 0; i < 16; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_id_d      = cur_id_q;
    last_id_d     = last_id_q;
    last_val_d    = last_val_q;
    last_val_ok_d = last_val_ok_q;
    val_id_d      = val_id_q;
    val_data_d    = val_data_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    error_d       = error_q;
    fetch_ready   = 1'b0;
    inc_req       = 1'b0;
    inc_retry     = 1'b0;
    inc_hit       = 1'b0;

    case (state_q)
      S_IDLE: begin
        fetch_ready = 1'b1;
        // Id 0 is the network idle code and is never fetched.
        if (fetch_valid && fetch_id != 6'd0) begin
          cur_id_d = fetch_id;
          if (fetch_id == last_id_q && last_val_ok_q) begin
            val_id_d   = fetch_id;
            val_data_d = last_val_q;
            inc_hit    = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        inc_req = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timer_q != 16'hFFFF) timer_d = timer_q + 16'd1;
        // The held response still carries last_id, so that id must never match.
        if (response[5:0] == cur_id_q && cur_id_q != last_id_q) begin
          val_id_d      = cur_id_q;
          val_data_d    = response[DATA_W+5:6];
          last_val_d    = response[DATA_W+5:6];
          last_id_d     = cur_id_q;
          last_val_ok_d = 1'b1;
          state_d       = S_DONE;
        end else if (timer_q == TIMEOUT_M1) begin
          if (retry_q < MAX_RETRY_W) begin
            retry_d   = retry_q + 8'd1;
            inc_retry = 1'b1;
            state_d   = S_GAP;
          end else begin
            error_d    = 1'b1;
            val_id_d   = cur_id_q;
            val_data_d = '0;
            state_d    = S_DONE;
          end
        end
      end
      S_GAP: begin
        state_d = S_ISSUE;
      end
      S_DONE: begin
        if (val_ready) begin
          retry_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < 16; i++) tbl_d[i] = tbl_q[i];
    if (tbl_we) begin
      tbl_d[tbl_addr] = tbl_wdata;
      // A local write of the cached page makes the cached remote copy stale.
      if (({1'b0, LOCAL_BASE} + {3'b000, tbl_addr}) == {1'b0, last_id_d}) last_val_ok_d = 1'b0;
    end
  end

  always_comb begin
    reply = '0;
    if ({1'b0, query_id} >= {1'b0, LOCAL_BASE} &&
        {1'b0, query_id} <= ({1'b0, LOCAL_BASE} + 7'd15)) begin
      reply = tbl_q[4'(query_id - LOCAL_BASE)];
    end
  end

  assign request   = (state_q == S_ISSUE || state_q == S_WAIT) ? cur_id_q : 6'd0;
  assign val_valid = (state_q == S_DONE);
  assign val_id    = val_id_q;
  assign val_data  = val_data_q;
  assign error     = error_q;

`ifdef NOC_PAGE_CLIENT_STATS_EN
  logic [15:0] stat_req_q, stat_req_d;
  logic [15:0] stat_retry_q, stat_retry_d;
  logic [15:0] stat_hit_q, stat_hit_d;

  always_comb begin
    stat_req_d   = stat_req_q + {15'd0, inc_req};
    stat_retry_d = stat_retry_q + {15'd0, inc_retry};
    stat_hit_d   = stat_hit_q + {15'd0, inc_hit};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_req_q   <= '0;
      stat_retry_q <= '0;
      stat_hit_q   <= '0;
    end else begin
      stat_req_q   <= stat_req_d;
      stat_retry_q <= stat_retry_d;
      stat_hit_q   <= stat_hit_d;
    end
  end

  assign stat_req   = stat_req_q;
  assign stat_retry = stat_retry_q;
  assign stat_hit   = stat_hit_q;
`else
  logic unused_stat_incs;
  assign unused_stat_incs = ^{inc_req, inc_retry, inc_hit};
  assign stat_req   = '0;
  assign stat_retry = '0;
  assign stat_hit   = '0;
`endif

endmodule
